// File: rtl/odom_pkg.sv
// rtl/odom_pkg.sv - shared types and defaults for the odometry sequencer
package odom_pkg;

  localparam int DATAWIDTH_N    = 32;
  localparam int FRACTIONAL_Q   = 15;
  localparam int PERIOD_CYCLES  = 500000;
  localparam int TIMEOUT_CYCLES = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_VEL_WAIT,
    ST_POS_WAIT,
    ST_ZERO
  } odom_state_e;

  // Counter width that still holds n-1 and is never zero bits wide.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/odom_sequencer_if.sv
// rtl/odom_sequencer_if.sv - sequencer handshake and snapshot bus bundle
interface odom_sequencer_if #(
  parameter int DATAWIDTH_N = odom_pkg::DATAWIDTH_N
) ();

  logic                   ODOM_SEQUENCER_ENABLE_In;
  logic                   ODOM_SEQUENCER_SETBEGIN_InLow;
  logic [DATAWIDTH_N-1:0] ODOM_SEQUENCER_W1_InBus;
  logic [DATAWIDTH_N-1:0] ODOM_SEQUENCER_W2_InBus;
  logic [DATAWIDTH_N-1:0] ODOM_SEQUENCER_W3_InBus;
  logic [DATAWIDTH_N-1:0] ODOM_SEQUENCER_W4_InBus;
  logic [DATAWIDTH_N-1:0] ODOM_SEQUENCER_THETA_InBus;
  logic                   ODOM_SEQUENCER_VEL_DONE_In;
  logic                   ODOM_SEQUENCER_POS_DONE_In;
  logic [DATAWIDTH_N-1:0] ODOM_SEQUENCER_W1_OutBus;
  logic [DATAWIDTH_N-1:0] ODOM_SEQUENCER_W2_OutBus;
  logic [DATAWIDTH_N-1:0] ODOM_SEQUENCER_W3_OutBus;
  logic [DATAWIDTH_N-1:0] ODOM_SEQUENCER_W4_OutBus;
  logic [DATAWIDTH_N-1:0] ODOM_SEQUENCER_THETA_OutBus;
  logic                   ODOM_SEQUENCER_VEL_START_Out;
  logic                   ODOM_SEQUENCER_POS_UPDATE_Out;
  logic                   ODOM_SEQUENCER_POS_SETBEGIN_OutLow;
  logic                   ODOM_SEQUENCER_BUSY_Out;
  logic                   ODOM_SEQUENCER_TIMEOUT_Out;
  logic                   ODOM_SEQUENCER_OVERRUN_Out;
  logic [15:0]            ODOM_SEQUENCER_SAMPLES_OutBus;

  // Sequencer side: consumes live data and done flags, issues commands.
  modport master (
    input  ODOM_SEQUENCER_ENABLE_In, ODOM_SEQUENCER_SETBEGIN_InLow,
    input  ODOM_SEQUENCER_W1_InBus, ODOM_SEQUENCER_W2_InBus,
    input  ODOM_SEQUENCER_W3_InBus, ODOM_SEQUENCER_W4_InBus,
    input  ODOM_SEQUENCER_THETA_InBus,
    input  ODOM_SEQUENCER_VEL_DONE_In, ODOM_SEQUENCER_POS_DONE_In,
    output ODOM_SEQUENCER_W1_OutBus, ODOM_SEQUENCER_W2_OutBus,
    output ODOM_SEQUENCER_W3_OutBus, ODOM_SEQUENCER_W4_OutBus,
    output ODOM_SEQUENCER_THETA_OutBus,
    output ODOM_SEQUENCER_VEL_START_Out, ODOM_SEQUENCER_POS_UPDATE_Out,
    output ODOM_SEQUENCER_POS_SETBEGIN_OutLow, ODOM_SEQUENCER_BUSY_Out,
    output ODOM_SEQUENCER_TIMEOUT_Out, ODOM_SEQUENCER_OVERRUN_Out,
    output ODOM_SEQUENCER_SAMPLES_OutBus
  );

  // Datapath side: supplies live data and done flags, follows commands.
  modport slave (
    output ODOM_SEQUENCER_ENABLE_In, ODOM_SEQUENCER_SETBEGIN_InLow,
    output ODOM_SEQUENCER_W1_InBus, ODOM_SEQUENCER_W2_InBus,
    output ODOM_SEQUENCER_W3_InBus, ODOM_SEQUENCER_W4_InBus,
    output ODOM_SEQUENCER_THETA_InBus,
    output ODOM_SEQUENCER_VEL_DONE_In, ODOM_SEQUENCER_POS_DONE_In,
    input  ODOM_SEQUENCER_W1_OutBus, ODOM_SEQUENCER_W2_OutBus,
    input  ODOM_SEQUENCER_W3_OutBus, ODOM_SEQUENCER_W4_OutBus,
    input  ODOM_SEQUENCER_THETA_OutBus,
    input  ODOM_SEQUENCER_VEL_START_Out, ODOM_SEQUENCER_POS_UPDATE_Out,
    input  ODOM_SEQUENCER_POS_SETBEGIN_OutLow, ODOM_SEQUENCER_BUSY_Out,
    input  ODOM_SEQUENCER_TIMEOUT_Out, ODOM_SEQUENCER_OVERRUN_Out,
    input  ODOM_SEQUENCER_SAMPLES_OutBus
  );

endinterface

// File: rtl/odom_sync_edge.sv
// rtl/odom_sync_edge.sv - 2-flop synchronizer with falling-edge detect
module odom_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic fall
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;

  // Shift the asynchronous input through two stages, keep last value.
  always_comb begin
    s1_d   = din;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  // Stages idle high so a released button never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign fall = prev_q & ~s2_q;

endmodule

// File: rtl/odom_sequencer.sv
// rtl/odom_sequencer.sv - periodic snapshot and velocity/integrator sequencer
module odom_sequencer
  import odom_pkg::*;
#(
  parameter int DATAWIDTH_N    = odom_pkg::DATAWIDTH_N,
  parameter int PERIOD_CYCLES  = odom_pkg::PERIOD_CYCLES,
  parameter int TIMEOUT_CYCLES = odom_pkg::TIMEOUT_CYCLES
) (
  input  logic              ODOM_SEQUENCER_CLOCK_50,
  input  logic              ODOM_SEQUENCER_Reset_InHigh,
  odom_sequencer_if.master  bus
);

  localparam int PW = cnt_width(PERIOD_CYCLES);
  localparam int TW = cnt_width(TIMEOUT_CYCLES);

  logic clk, rst;
  assign clk = ODOM_SEQUENCER_CLOCK_50;
  assign rst = ODOM_SEQUENCER_Reset_InHigh;

  odom_state_e            state_q, state_d;
  logic [PW-1:0]          per_q, per_d;
  logic [TW-1:0]          to_q, to_d;
  logic [DATAWIDTH_N-1:0] w1_q, w1_d, w2_q, w2_d, w3_q, w3_d, w4_q, w4_d;
  logic [DATAWIDTH_N-1:0] theta_q, theta_d;
  logic                   vel_start_q, vel_start_d;
  logic                   pos_update_q, pos_update_d;
  logic                   setbegin_n_q, setbegin_n_d;
  logic                   timeout_q, timeout_d;
  logic                   overrun_q, overrun_d;
  logic                   pending_q, pending_d;
  logic [15:0]            samples_q, samples_d;
  logic                   zero_fall;
  logic                   tick;

  odom_sync_edge u_setbegin_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.ODOM_SEQUENCER_SETBEGIN_InLow),
    .fall (zero_fall)
  );

  assign tick = bus.ODOM_SEQUENCER_ENABLE_In && (per_q == PW'(PERIOD_CYCLES - 1));

  // Next-state, period counter, snapshot capture and flag updates.
  always_comb begin
    state_d      = state_q;
    to_d         = to_q + 1'b1;
    w1_d         = w1_q;
    w2_d         = w2_q;
    w3_d         = w3_q;
    w4_d         = w4_q;
    theta_d      = theta_q;
    vel_start_d  = 1'b0;
    pos_update_d = 1'b0;
    samples_d    = samples_q;
    timeout_d    = timeout_q;
    overrun_d    = overrun_q;
    pending_d    = pending_q | zero_fall;

    if (!bus.ODOM_SEQUENCER_ENABLE_In || tick) per_d = '0;
    else                                       per_d = per_q + 1'b1;

    // A tick the sequence cannot take is lost, but recorded.
    if (tick && state_q != ST_IDLE) overrun_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (pending_q) state_d = ST_ZERO;
        else if (tick) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        w1_d        = bus.ODOM_SEQUENCER_W1_InBus;
        w2_d        = bus.ODOM_SEQUENCER_W2_InBus;
        w3_d        = bus.ODOM_SEQUENCER_W3_InBus;
        w4_d        = bus.ODOM_SEQUENCER_W4_InBus;
        theta_d     = bus.ODOM_SEQUENCER_THETA_InBus;
        to_d        = '0;
        vel_start_d = 1'b1;
        state_d     = ST_VEL_WAIT;
      end
      ST_VEL_WAIT: begin
        // A done level left over from the last sample is ignored while
        // the start pulse is still out.
        if (bus.ODOM_SEQUENCER_VEL_DONE_In && !vel_start_q) begin
          to_d         = '0;
          pos_update_d = 1'b1;
          state_d      = ST_POS_WAIT;
        end else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_POS_WAIT: begin
        if (bus.ODOM_SEQUENCER_POS_DONE_In && !pos_update_q) begin
          samples_d = samples_q + 16'd1;
          state_d   = ST_IDLE;
        end else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_ZERO: begin
        samples_d = '0;
        timeout_d = 1'b0;
        overrun_d = 1'b0;
        pending_d = zero_fall;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    setbegin_n_d = (state_d != ST_ZERO);
  end

  // State and output registers; every command output is a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      per_q        <= '0;
      to_q         <= '0;
      w1_q         <= '0;
      w2_q         <= '0;
      w3_q         <= '0;
      w4_q         <= '0;
      theta_q      <= '0;
      vel_start_q  <= 1'b0;
      pos_update_q <= 1'b0;
      setbegin_n_q <= 1'b1;
      samples_q    <= '0;
      timeout_q    <= 1'b0;
      overrun_q    <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      per_q        <= per_d;
      to_q         <= to_d;
      w1_q         <= w1_d;
      w2_q         <= w2_d;
      w3_q         <= w3_d;
      w4_q         <= w4_d;
      theta_q      <= theta_d;
      vel_start_q  <= vel_start_d;
      pos_update_q <= pos_update_d;
      setbegin_n_q <= setbegin_n_d;
      samples_q    <= samples_d;
      timeout_q    <= timeout_d;
      overrun_q    <= overrun_d;
      pending_q    <= pending_d;
    end
  end

  assign bus.ODOM_SEQUENCER_W1_OutBus           = w1_q;
  assign bus.ODOM_SEQUENCER_W2_OutBus           = w2_q;
  assign bus.ODOM_SEQUENCER_W3_OutBus           = w3_q;
  assign bus.ODOM_SEQUENCER_W4_OutBus           = w4_q;
  assign bus.ODOM_SEQUENCER_THETA_OutBus        = theta_q;
  assign bus.ODOM_SEQUENCER_VEL_START_Out       = vel_start_q;
  assign bus.ODOM_SEQUENCER_POS_UPDATE_Out      = pos_update_q;
  assign bus.ODOM_SEQUENCER_POS_SETBEGIN_OutLow = setbegin_n_q;
  assign bus.ODOM_SEQUENCER_BUSY_Out            = (state_q != ST_IDLE);
  assign bus.ODOM_SEQUENCER_TIMEOUT_Out         = timeout_q;
  assign bus.ODOM_SEQUENCER_OVERRUN_Out         = overrun_q;
  assign bus.ODOM_SEQUENCER_SAMPLES_OutBus      = samples_q;

endmodule

// File: tb/tb_odom_sequencer.sv
// tb/tb_odom_sequencer.sv - directed bench for odom_sequencer
module tb_odom_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   pulses;

  always #5 clk = ~clk;

  odom_sequencer_if #(.DATAWIDTH_N(32)) bus ();

  odom_sequencer #(
    .DATAWIDTH_N    (32),
    .PERIOD_CYCLES  (20),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .ODOM_SEQUENCER_CLOCK_50     (clk),
    .ODOM_SEQUENCER_Reset_InHigh (rst),
    .bus                         (bus.master)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n cycles and land 1 time unit after the active edge.
  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.ODOM_SEQUENCER_ENABLE_In      = 1'b0;
    bus.ODOM_SEQUENCER_SETBEGIN_InLow = 1'b1;
    bus.ODOM_SEQUENCER_W1_InBus       = 32'h0001_8000;
    bus.ODOM_SEQUENCER_W2_InBus       = 32'h0000_4000;
    bus.ODOM_SEQUENCER_W3_InBus       = 32'hFFFF_8000;
    bus.ODOM_SEQUENCER_W4_InBus       = 32'h0002_0000;
    bus.ODOM_SEQUENCER_THETA_InBus    = 32'h002D_0000;
    bus.ODOM_SEQUENCER_VEL_DONE_In    = 1'b0;
    bus.ODOM_SEQUENCER_POS_DONE_In    = 1'b0;

    adv(3);
    chk("rst_busy", bus.ODOM_SEQUENCER_BUSY_Out, 0);
    chk("rst_w1", bus.ODOM_SEQUENCER_W1_OutBus, 0);
    chk("rst_samples", bus.ODOM_SEQUENCER_SAMPLES_OutBus, 0);
    chk("rst_setbegin", bus.ODOM_SEQUENCER_POS_SETBEGIN_OutLow, 1);
    chk("rst_vel_start", bus.ODOM_SEQUENCER_VEL_START_Out, 0);
    chk("rst_timeout", bus.ODOM_SEQUENCER_TIMEOUT_Out, 0);
    rst = 1'b0;
    adv(2);

    // cycle 0: enable rises; ticks at 19, 39, 59, ...
    bus.ODOM_SEQUENCER_ENABLE_In = 1'b1;
    adv(20);  // 20 (LATCH)
    chk("c20_vel_start", bus.ODOM_SEQUENCER_VEL_START_Out, 0);
    chk("c20_busy", bus.ODOM_SEQUENCER_BUSY_Out, 1);
    chk("c20_w1_old", bus.ODOM_SEQUENCER_W1_OutBus, 0);
    adv(1);   // 21
    chk("c21_vel_start", bus.ODOM_SEQUENCER_VEL_START_Out, 1);
    chk("c21_w1", bus.ODOM_SEQUENCER_W1_OutBus, 32'h0001_8000);
    chk("c21_w3", bus.ODOM_SEQUENCER_W3_OutBus, 32'hFFFF_8000);
    chk("c21_theta", bus.ODOM_SEQUENCER_THETA_OutBus, 32'h002D_0000);
    bus.ODOM_SEQUENCER_W1_InBus    = 32'h1111_1111;
    bus.ODOM_SEQUENCER_THETA_InBus = 32'h2222_2222;
    adv(1);   // 22
    chk("c22_vel_start", bus.ODOM_SEQUENCER_VEL_START_Out, 0);
    adv(3);   // 25
    bus.ODOM_SEQUENCER_VEL_DONE_In = 1'b1;
    adv(1);   // 26
    bus.ODOM_SEQUENCER_VEL_DONE_In = 1'b0;
    chk("c26_pos_update", bus.ODOM_SEQUENCER_POS_UPDATE_Out, 1);
    adv(1);   // 27
    chk("c27_pos_update", bus.ODOM_SEQUENCER_POS_UPDATE_Out, 0);
    adv(1);   // 28
    bus.ODOM_SEQUENCER_POS_DONE_In = 1'b1;
    adv(1);   // 29
    bus.ODOM_SEQUENCER_POS_DONE_In = 1'b0;
    chk("c29_samples", bus.ODOM_SEQUENCER_SAMPLES_OutBus, 1);
    chk("c29_busy", bus.ODOM_SEQUENCER_BUSY_Out, 0);
    chk("c29_w1_stable", bus.ODOM_SEQUENCER_W1_OutBus, 32'h0001_8000);

    // tick 39: VEL_DONE never arrives, timeout 16 cycles after the start
    adv(12);  // 41
    chk("c41_vel_start", bus.ODOM_SEQUENCER_VEL_START_Out, 1);
    chk("c41_w1", bus.ODOM_SEQUENCER_W1_OutBus, 32'h1111_1111);
    chk("c41_theta", bus.ODOM_SEQUENCER_THETA_OutBus, 32'h2222_2222);
    adv(15);  // 56
    chk("c56_timeout", bus.ODOM_SEQUENCER_TIMEOUT_Out, 0);
    chk("c56_busy", bus.ODOM_SEQUENCER_BUSY_Out, 1);
    adv(1);   // 57
    chk("c57_timeout", bus.ODOM_SEQUENCER_TIMEOUT_Out, 1);
    chk("c57_busy", bus.ODOM_SEQUENCER_BUSY_Out, 0);
    chk("c57_samples", bus.ODOM_SEQUENCER_SAMPLES_OutBus, 1);

    // tick 59: restart; done in the start cycle is ignored; overrun at 79
    adv(4);   // 61
    chk("c61_vel_start", bus.ODOM_SEQUENCER_VEL_START_Out, 1);
    chk("c61_timeout_sticky", bus.ODOM_SEQUENCER_TIMEOUT_Out, 1);
    bus.ODOM_SEQUENCER_VEL_DONE_In = 1'b1;
    adv(1);   // 62
    bus.ODOM_SEQUENCER_VEL_DONE_In = 1'b0;
    chk("c62_pos_update", bus.ODOM_SEQUENCER_POS_UPDATE_Out, 0);
    chk("c62_busy", bus.ODOM_SEQUENCER_BUSY_Out, 1);
    adv(8);   // 70
    bus.ODOM_SEQUENCER_VEL_DONE_In = 1'b1;
    adv(1);   // 71
    bus.ODOM_SEQUENCER_VEL_DONE_In = 1'b0;
    chk("c71_pos_update", bus.ODOM_SEQUENCER_POS_UPDATE_Out, 1);
    pulses = 0;
    for (int i = 72; i <= 78; i++) begin
      adv(1);
      pulses += int'(bus.ODOM_SEQUENCER_POS_UPDATE_Out);
    end       // 78
    chk("c78_overrun", bus.ODOM_SEQUENCER_OVERRUN_Out, 0);
    adv(2);   // 80
    pulses += int'(bus.ODOM_SEQUENCER_POS_UPDATE_Out);
    chk("c80_overrun", bus.ODOM_SEQUENCER_OVERRUN_Out, 1);
    chk("c80_busy", bus.ODOM_SEQUENCER_BUSY_Out, 1);
    adv(1);   // 81
    pulses += int'(bus.ODOM_SEQUENCER_POS_UPDATE_Out);
    chk("c81_no_vel_start", bus.ODOM_SEQUENCER_VEL_START_Out, 0);
    adv(1);   // 82
    pulses += int'(bus.ODOM_SEQUENCER_POS_UPDATE_Out);
    bus.ODOM_SEQUENCER_POS_DONE_In = 1'b1;
    adv(1);   // 83
    bus.ODOM_SEQUENCER_POS_DONE_In = 1'b0;
    chk("extra_pos_update", pulses, 0);
    chk("c83_samples", bus.ODOM_SEQUENCER_SAMPLES_OutBus, 2);
    chk("c83_busy", bus.ODOM_SEQUENCER_BUSY_Out, 0);

    // tick 99: SETBEGIN during POS_WAIT waits for POS_DONE
    adv(18);  // 101
    chk("c101_vel_start", bus.ODOM_SEQUENCER_VEL_START_Out, 1);
    adv(2);   // 103
    bus.ODOM_SEQUENCER_VEL_DONE_In = 1'b1;
    adv(1);   // 104
    bus.ODOM_SEQUENCER_VEL_DONE_In = 1'b0;
    chk("c104_pos_update", bus.ODOM_SEQUENCER_POS_UPDATE_Out, 1);
    adv(1);   // 105
    bus.ODOM_SEQUENCER_SETBEGIN_InLow = 1'b0;
    adv(1);   // 106
    bus.ODOM_SEQUENCER_SETBEGIN_InLow = 1'b1;
    pulses = 0;
    for (int i = 107; i <= 110; i++) begin
      adv(1);
      pulses += int'(!bus.ODOM_SEQUENCER_POS_SETBEGIN_OutLow);
    end       // 110
    bus.ODOM_SEQUENCER_POS_DONE_In = 1'b1;
    adv(1);   // 111
    bus.ODOM_SEQUENCER_POS_DONE_In = 1'b0;
    pulses += int'(!bus.ODOM_SEQUENCER_POS_SETBEGIN_OutLow);
    chk("early_setbegin", pulses, 0);
    chk("c111_samples", bus.ODOM_SEQUENCER_SAMPLES_OutBus, 3);
    chk("c111_overrun", bus.ODOM_SEQUENCER_OVERRUN_Out, 1);
    adv(1);   // 112 (ZERO)
    chk("c112_setbegin", bus.ODOM_SEQUENCER_POS_SETBEGIN_OutLow, 0);
    chk("c112_busy", bus.ODOM_SEQUENCER_BUSY_Out, 1);
    adv(1);   // 113
    chk("c113_setbegin", bus.ODOM_SEQUENCER_POS_SETBEGIN_OutLow, 1);
    chk("c113_samples", bus.ODOM_SEQUENCER_SAMPLES_OutBus, 0);
    chk("c113_timeout", bus.ODOM_SEQUENCER_TIMEOUT_Out, 0);
    chk("c113_overrun", bus.ODOM_SEQUENCER_OVERRUN_Out, 0);
    chk("c113_busy", bus.ODOM_SEQUENCER_BUSY_Out, 0);

    // SETBEGIN edge reaches IDLE together with tick 119
    adv(3);   // 116
    bus.ODOM_SEQUENCER_SETBEGIN_InLow = 1'b0;
    adv(1);   // 117
    bus.ODOM_SEQUENCER_SETBEGIN_InLow = 1'b1;
    adv(3);   // 120
    chk("c120_setbegin", bus.ODOM_SEQUENCER_POS_SETBEGIN_OutLow, 0);
    chk("c120_overrun", bus.ODOM_SEQUENCER_OVERRUN_Out, 0);
    adv(1);   // 121
    chk("c121_no_vel_start", bus.ODOM_SEQUENCER_VEL_START_Out, 0);
    chk("c121_busy", bus.ODOM_SEQUENCER_BUSY_Out, 0);
    chk("c121_overrun", bus.ODOM_SEQUENCER_OVERRUN_Out, 0);
    chk("c121_setbegin", bus.ODOM_SEQUENCER_POS_SETBEGIN_OutLow, 1);
    adv(20);  // 141
    chk("c141_vel_start", bus.ODOM_SEQUENCER_VEL_START_Out, 1);
    chk("c141_busy", bus.ODOM_SEQUENCER_BUSY_Out, 1);

    // asynchronous reset in the middle of VEL_WAIT
    adv(1);   // 142
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", bus.ODOM_SEQUENCER_BUSY_Out, 0);
    chk("arst_w1", bus.ODOM_SEQUENCER_W1_OutBus, 0);
    chk("arst_theta", bus.ODOM_SEQUENCER_THETA_OutBus, 0);
    chk("arst_samples", bus.ODOM_SEQUENCER_SAMPLES_OutBus, 0);
    chk("arst_setbegin", bus.ODOM_SEQUENCER_POS_SETBEGIN_OutLow, 1);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      adv(1);
      pulses += int'(bus.ODOM_SEQUENCER_VEL_START_Out);
      pulses += int'(bus.ODOM_SEQUENCER_POS_UPDATE_Out);
    end
    chk("arst_no_pulse", pulses, 0);
    rst = 1'b0;
    adv(2);
    chk("post_rst_busy", bus.ODOM_SEQUENCER_BUSY_Out, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
